// File: rtl/cpu_pkg.sv
// Shared CPU definitions.
// Holds the memory-handler FSM state type and byte-lane constants, plus the
// decoder enums (function op, branch kind, instruction format) used across
// the core.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mem_state_t;

  typedef enum logic [2:0] {
    FOP_ADD,
    FOP_SUB,
    FOP_AND,
    FOP_OR,
    FOP_XOR,
    FOP_SLT,
    FOP_SLL,
    FOP_SRL
  } fop_t;

  typedef enum logic [2:0] {
    B_NONE,
    B_EQ,
    B_NE,
    B_LT,
    B_GE,
    B_JAL
  } b_t;

  typedef enum logic [2:0] {
    R_TYPE,
    I_TYPE,
    S_TYPE,
    B_TYPE,
    U_TYPE,
    J_TYPE
  } inst_type;

  localparam logic [3:0] SEL_WORD  = 4'hF;
  localparam logic [3:0] SEL_BYTE0 = 4'h1;

endpackage

// File: rtl/byte_lane_unit.sv
// Byte-lane steering for data-memory accesses (purely combinational).
// Ports:
//   size_byte_i  : 1 = byte access, 0 = word access
//   addr_lo_i    : addr[1:0], selects the byte lane
//   store_data_i : store value (rs2)
//   bus_rdata_i  : raw read data from the bus
//   bus_sel_o    : byte-lane enables
//   bus_wdata_o  : write data, byte replicated on all lanes for byte stores
//   load_val_o   : load result, sign-extended for byte loads
module byte_lane_unit
  import cpu_pkg::*;
(
  input  logic        size_byte_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] bus_rdata_i,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  output logic [31:0] load_val_o
);

  logic [7:0] lane;

  always_comb begin
    lane        = bus_rdata_i[{addr_lo_i, 3'b000} +: 8];
    bus_sel_o   = SEL_WORD;
    bus_wdata_o = store_data_i;
    load_val_o  = bus_rdata_i;
    if (size_byte_i) begin
      bus_sel_o   = SEL_BYTE0 << addr_lo_i;
      bus_wdata_o = {4{store_data_i[7:0]}};
      load_val_o  = {{24{lane[7]}}, lane};
    end
  end

endmodule

// File: rtl/memory_handler.sv
// Data-memory access unit: runs one load/store at a time on a single-outstanding
// req/ack bus and stalls the pipeline until it completes, errors or times out.
// Ports:
//   clk, nrst                      : clock, synchronous active-low reset
//   read_mem, write_mem            : load / store request (write wins if both)
//   load_byte, store_byte          : byte size for loads / stores, else word
//   addr, store_data               : effective address and store value
//   bus_rdata, bus_ack             : bus read data and completion
//   bus_read, bus_write            : bus requests, held until ack
//   bus_addr, bus_wdata, bus_sel   : word-aligned address, write data, lane mask
//   load_data                      : load result for writeback
//   freeze                         : pipeline stall
//   mem_done, mem_err              : one-cycle completion / error pulses
module memory_handler
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        read_mem,
  input  logic        write_mem,
  input  logic        load_byte,
  input  logic        store_byte,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  output logic [31:0] load_data,
  output logic        freeze,
  output logic        mem_done,
  output logic        mem_err
);

  mem_state_t       state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      sdata_q, sdata_d;
  logic             byte_q, byte_d;
  logic             write_q, write_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      load_data_q, load_data_d;

  logic             req;
  logic             req_byte;
  logic [3:0]       lane_sel;
  logic [31:0]      lane_wdata;
  logic [31:0]      lane_load;

  assign req      = read_mem | write_mem;
  assign req_byte = write_mem ? store_byte : load_byte;

  // Lane unit works on the latched request so bus outputs stay stable in BUSY.
  byte_lane_unit u_byte_lane_unit (
    .size_byte_i  (byte_q),
    .addr_lo_i    (addr_q[1:0]),
    .store_data_i (sdata_q),
    .bus_rdata_i  (bus_rdata),
    .bus_sel_o    (lane_sel),
    .bus_wdata_o  (lane_wdata),
    .load_val_o   (lane_load)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    sdata_d     = sdata_q;
    byte_d      = byte_q;
    write_d     = write_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    load_data_d = load_data_q;
    bus_read    = 1'b0;
    bus_write   = 1'b0;
    bus_addr    = '0;
    bus_wdata   = '0;
    bus_sel     = '0;
    freeze      = 1'b0;
    mem_done    = 1'b0;
    mem_err     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          freeze  = 1'b1;
          addr_d  = addr;
          sdata_d = store_data;
          byte_d  = req_byte;
          write_d = write_mem;
          cnt_d   = '0;
          if (!req_byte && (addr[1:0] != 2'b00)) begin
            // Misaligned word: fail without touching the bus.
            err_d   = 1'b1;
            state_d = DONE;
            if (!write_mem) load_data_d = '0;
          end else begin
            err_d   = 1'b0;
            state_d = BUSY;
          end
        end
      end

      BUSY: begin
        freeze    = 1'b1;
        bus_read  = ~write_q;
        bus_write = write_q;
        bus_addr  = {addr_q[31:2], 2'b00};
        bus_wdata = write_q ? lane_wdata : '0;
        bus_sel   = lane_sel;
        if (bus_ack) begin
          // Ack beats the timeout even in the final cycle.
          if (!write_q) load_data_d = lane_load;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
          if (!write_q) load_data_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        mem_done = 1'b1;
        mem_err  = err_q;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      sdata_q     <= '0;
      byte_q      <= 1'b0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      sdata_q     <= sdata_d;
      byte_q      <= byte_d;
      write_q     <= write_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      load_data_q <= load_data_d;
    end
  end

  assign load_data = load_data_q;

endmodule

// File: tb/tb_memory_handler.sv
module tb_memory_handler;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        nrst;
  logic        read_mem, write_mem, load_byte, store_byte;
  logic [31:0] addr, store_data, bus_rdata;
  logic        bus_ack;
  logic        bus_read, bus_write;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_sel;
  logic [31:0] load_data;
  logic        freeze, mem_done, mem_err;

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] exp_ld     = '0;

  memory_handler #(
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (5)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .read_mem   (read_mem),
    .write_mem  (write_mem),
    .load_byte  (load_byte),
    .store_byte (store_byte),
    .addr       (addr),
    .store_data (store_data),
    .bus_rdata  (bus_rdata),
    .bus_ack    (bus_ack),
    .bus_read   (bus_read),
    .bus_write  (bus_write),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_sel    (bus_sel),
    .load_data  (load_data),
    .freeze     (freeze),
    .mem_done   (mem_done),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // One full transaction from request to the idle cycle after DONE.
  // delay = number of BUSY cycles without ack before the ack; >= TO never acks.
  task automatic txn(input bit rd, input bit wr, input bit lb, input bit sb,
                     input logic [31:0] a, input logic [31:0] sd,
                     input logic [31:0] rdata, input int delay);
    bit          byt, mis, acked, timed_out;
    int          k, busy_cycles;
    logic [3:0]  esel;
    logic [31:0] ewd, bv, eld;
    byt  = wr ? sb : lb;
    mis  = !byt && (a[1:0] != 2'b00);
    k    = int'(a[1:0]);
    esel = byt ? 4'(1 << k) : 4'hF;
    ewd  = byt ? (32'(sd[7:0]) * 32'h0101_0101) : sd;
    bv   = (rdata >> (8 * k)) & 32'hFF;
    eld  = byt ? ((bv >= 32'd128) ? (bv | 32'hFFFF_FF00) : bv) : rdata;
    acked = 1'b0;
    busy_cycles = 0;

    read_mem = rd; write_mem = wr; load_byte = lb; store_byte = sb;
    addr = a; store_data = sd; bus_ack = 1'b0; bus_rdata = $urandom;
    @(negedge clk);
    check("req_freeze", freeze, 1);
    check("req_no_bus", {bus_read, bus_write}, 0);
    check("req_no_done", mem_done, 0);
    next_edge();
    // Scramble inputs to prove the request was latched.
    read_mem = 1'b0; write_mem = 1'b0; addr = $urandom; store_data = $urandom;
    load_byte = 1'(~lb); store_byte = 1'(~sb);

    if (!mis) begin
      while (!acked && busy_cycles < int'(TO)) begin
        bus_ack   = (busy_cycles == delay);
        bus_rdata = bus_ack ? rdata : $urandom;
        @(negedge clk);
        check("busy_read", bus_read, !wr);
        check("busy_write", bus_write, wr);
        check("busy_addr", bus_addr, {a[31:2], 2'b00});
        check("busy_sel", bus_sel, esel);
        if (wr) check("busy_wdata", bus_wdata, ewd);
        check("busy_freeze", freeze, 1);
        check("busy_no_done", mem_done, 0);
        acked = bus_ack;
        busy_cycles++;
        next_edge();
      end
      bus_ack = 1'b0;
    end
    timed_out = !mis && !acked;
    if (!wr) exp_ld = (mis || timed_out) ? 32'h0 : eld;

    @(negedge clk);
    check("done_pulse", mem_done, 1);
    check("done_err", mem_err, mis | timed_out);
    check("done_freeze", freeze, 0);
    check("done_no_bus", {bus_read, bus_write}, 0);
    check("done_load", load_data, exp_ld);
    next_edge();

    @(negedge clk);
    check("idle_done", mem_done, 0);
    check("idle_freeze", freeze, 0);
    check("idle_load", load_data, exp_ld);
    next_edge();
  endtask

  initial begin
    bit          rd, wr;
    int          r, dly;
    logic [31:0] a;

    nrst = 1'b0; read_mem = 1'b0; write_mem = 1'b0; load_byte = 1'b0; store_byte = 1'b0;
    addr = '0; store_data = '0; bus_rdata = '0; bus_ack = 1'b0;
    next_edge();
    next_edge();
    @(negedge clk);
    check("rst_bus", {bus_read, bus_write}, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_wdata", bus_wdata, 0);
    check("rst_sel", bus_sel, 0);
    check("rst_load", load_data, 0);
    check("rst_flags", {freeze, mem_done, mem_err}, 0);
    nrst = 1'b1;
    next_edge();

    // Directed cases.
    txn(1, 0, 0, 0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);      // lw, zero wait
    txn(1, 0, 1, 0, 32'h0000_0103, 32'h0, 32'h8011_2233, 1);      // lb, negative byte
    txn(1, 0, 1, 0, 32'h0000_0101, 32'h0, 32'h8011_2233, 0);      // lb, positive byte
    txn(0, 1, 0, 1, 32'h0000_0202, 32'h0000_00A5, 32'h0, 0);      // sb lane 2
    txn(0, 1, 0, 0, 32'h0000_0102, 32'h1234_5678, 32'h0, 0);      // sw misaligned
    txn(1, 0, 0, 0, 32'h0000_0104, 32'h0, 32'hCAFE_F00D, 2);      // lw, sets nonzero load
    txn(1, 0, 0, 0, 32'h0000_0108, 32'h0, 32'h1111_1111, int'(TO));     // timeout
    txn(1, 0, 0, 0, 32'h0000_010C, 32'h0, 32'h5555_AAAA, int'(TO) - 1); // ack in last cycle
    txn(1, 1, 0, 0, 32'h0000_0040, 32'h0BAD_CAFE, 32'h0, 0);      // both set: write wins
    txn(1, 0, 0, 0, 32'h0000_0200, 32'h0, 32'h7777_0001, 0);      // nonzero load before reset

    // Reset during BUSY with a concurrent ack.
    read_mem = 1'b1; load_byte = 1'b0; addr = 32'h0000_0300; bus_ack = 1'b0;
    next_edge();
    read_mem = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", bus_read, 1);
    next_edge();
    nrst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h9999_9999;
    next_edge();
    exp_ld = '0;
    @(negedge clk);
    check("rst_busy_bus", {bus_read, bus_write}, 0);
    check("rst_busy_flags", {freeze, mem_done, mem_err}, 0);
    check("rst_busy_load", load_data, 0);
    nrst = 1'b1;
    next_edge();
    @(negedge clk);
    check("late_ack_ignored", {mem_done, bus_read, freeze}, 0);
    bus_ack = 1'b0;
    next_edge();

    // Randomized transactions.
    for (int i = 0; i < 40; i++) begin
      rd = 1'($urandom % 2);
      wr = rd ? 1'($urandom % 2) : 1'b1;
      a  = $urandom;
      if ($urandom % 4 != 0) a[1:0] = 2'b00;
      r = int'($urandom % 10);
      if (r == 0) dly = int'(TO);
      else if (r == 1) dly = int'(TO) - 1;
      else dly = int'($urandom % 4);
      txn(rd, wr, 1'($urandom % 2), 1'($urandom % 2), a, $urandom, $urandom, dly);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
